// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and load/store.
// Optional MEM_ARBITER_STATS_EN adds saturating grant/conflict counters.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_funct3,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_funct3,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef MEM_ARBITER_STATS_EN
  ,
  output logic [15:0]       if_gnt_cnt,
  output logic [15:0]       d_gnt_cnt,
  output logic [15:0]       conflict_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE, S_ACCESS, S_WAIT, S_RESP
  } state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;
  localparam logic [1:0] LAT_M1 = 2'(RD_LATENCY - 1);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_win, d_win;

  // On a tie the requester that did not own the last transaction wins.
  assign if_win = if_req & (~d_req | (last_q == OWN_D));
  assign d_win  = d_req & (~if_req | (last_q == OWN_IF));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_IF;
      last_q     <= OWN_D;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      f3_q       <= '0;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      f3_q       <= f3_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    f3_d       = f3_q;
    cnt_d      = cnt_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          if_win: begin
            if_gnt  = 1'b1;
            owner_d = OWN_IF;
            last_d  = OWN_IF;
            we_d    = 1'b0;
            addr_d  = if_addr;
            f3_d    = 3'b010;
            state_d = S_ACCESS;
          end
          d_win: begin
            d_gnt   = 1'b1;
            owner_d = OWN_D;
            last_d  = OWN_D;
            we_d    = d_we;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            f3_d    = d_funct3;
            state_d = S_ACCESS;
          end
          default: ;
        endcase
      end
      S_ACCESS: begin
        if (we_q) begin
          d_rdata_d = '0;
          state_d   = S_RESP;
        end else begin
          cnt_d   = LAT_M1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          if (owner_q == OWN_D) d_rdata_d = mem_rdata;
          else                  if_rdata_d = mem_rdata;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign mem_wren   = (state_q == S_ACCESS) & we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_funct3 = f3_q;
  assign if_rvalid  = (state_q == S_RESP) & (owner_q == OWN_IF);
  assign d_rvalid   = (state_q == S_RESP) & (owner_q == OWN_D);
  assign if_rdata   = if_rdata_q;
  assign d_rdata    = d_rdata_q;

`ifdef MEM_ARBITER_STATS_EN
  logic [15:0] if_cnt_q, if_cnt_d;
  logic [15:0] d_cnt_q, d_cnt_d;
  logic [15:0] cf_cnt_q, cf_cnt_d;
  logic        conflict;

  assign conflict = (state_q == S_IDLE) & if_req & d_req;

  always_comb begin
    if_cnt_d = if_cnt_q;
    d_cnt_d  = d_cnt_q;
    cf_cnt_d = cf_cnt_q;
    if (if_gnt && if_cnt_q != 16'hFFFF)   if_cnt_d = if_cnt_q + 16'd1;
    if (d_gnt && d_cnt_q != 16'hFFFF)     d_cnt_d  = d_cnt_q + 16'd1;
    if (conflict && cf_cnt_q != 16'hFFFF) cf_cnt_d = cf_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_cnt_q <= '0;
      d_cnt_q  <= '0;
      cf_cnt_q <= '0;
    end else begin
      if_cnt_q <= if_cnt_d;
      d_cnt_q  <= d_cnt_d;
      cf_cnt_q <= cf_cnt_d;
    end
  end

  assign if_gnt_cnt   = if_cnt_q;
  assign d_gnt_cnt    = d_cnt_q;
  assign conflict_cnt = cf_cnt_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (RD_LATENCY = 3).
// Memory model returns data only in the cycle RD_LATENCY after ACCESS.
module tb_mem_arbiter;

  localparam int LAT = 3;

  logic        clk;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_funct3;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_wren;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_rdata;
  logic        busy;
`ifdef MEM_ARBITER_STATS_EN
  logic [15:0] if_gnt_cnt;
  logic [15:0] d_gnt_cnt;
  logic [15:0] conflict_cnt;
`endif

  int checks = 0;
  int fails  = 0;

  mem_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .RD_LATENCY(LAT)
  ) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_funct3  (d_funct3),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_wren  (mem_wren),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_funct3(mem_funct3),
    .mem_rdata (mem_rdata),
    .busy      (busy)
`ifdef MEM_ARBITER_STATS_EN
    ,
    .if_gnt_cnt  (if_gnt_cnt),
    .d_gnt_cnt   (d_gnt_cnt),
    .conflict_cnt(conflict_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents: 0x1000 holds addi x1,x0,5; elsewhere addr ^ 0x5A5A0000.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h1000) ? 32'h00500093 : (a ^ 32'h5A5A0000);
  endfunction

  bit          busy_d = 1'b0;
  bit   [3:0]  acc_p  = 4'b0;
  logic [31:0] ap [0:3];

  always @(posedge clk) begin
    busy_d <= busy;
    acc_p  <= {acc_p[2:0], busy & ~busy_d};
    ap[0]  <= mem_addr;
    ap[1]  <= ap[0];
    ap[2]  <= ap[1];
    ap[3]  <= ap[2];
  end

  assign mem_rdata = acc_p[LAT-1] ? mem_word(ap[LAT-1]) : 32'hBAD0BAD0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic run_if(input logic [31:0] a, input logic [31:0] exp);
    int n;
    step();
    if_req  = 1'b1;
    if_addr = a;
    #1;
    check("if_gnt", if_gnt, 1);
    check("if_no_dgnt", d_gnt, 0);
    step();
    if_req = 1'b0;
    #1;
    n = 1;
    check("if_mem_addr", mem_addr, a);
    check("if_mem_f3", mem_funct3, 3'b010);
    check("if_mem_wren", mem_wren, 0);
    while (!if_rvalid && n < 20) begin
      step();
      #1;
      n++;
    end
    check("if_latency", n, LAT + 2);
    check("if_rdata", if_rdata, exp);
  endtask

  task automatic run_ld(input logic [31:0] a, input logic [31:0] exp);
    int n;
    step();
    d_req    = 1'b1;
    d_we     = 1'b0;
    d_addr   = a;
    d_funct3 = 3'b100;
    #1;
    check("ld_gnt", d_gnt, 1);
    step();
    d_req = 1'b0;
    #1;
    n = 1;
    check("ld_mem_f3", mem_funct3, 3'b100);
    check("ld_mem_wren", mem_wren, 0);
    while (!d_rvalid && n < 20) begin
      step();
      #1;
      n++;
    end
    check("ld_latency", n, LAT + 2);
    check("ld_rdata", d_rdata, exp);
    check("ld_no_ifrv", if_rvalid, 0);
  endtask

  task automatic run_st(input logic [31:0] a, input logic [31:0] wd);
    int n;
    int wr;
    step();
    d_req    = 1'b1;
    d_we     = 1'b1;
    d_addr   = a;
    d_wdata  = wd;
    d_funct3 = 3'b010;
    #1;
    check("st_gnt", d_gnt, 1);
    check("st_no_ifgnt", if_gnt, 0);
    step();
    d_req = 1'b0;
    d_we  = 1'b0;
    #1;
    n  = 1;
    wr = mem_wren ? 1 : 0;
    check("st_mem_addr", mem_addr, a);
    check("st_mem_wdata", mem_wdata, wd);
    check("st_mem_f3", mem_funct3, 3'b010);
    while (!d_rvalid && n < 20) begin
      step();
      #1;
      n++;
      if (mem_wren) wr++;
    end
    check("st_latency", n, 2);
    check("st_wren_cycles", wr, 1);
    check("st_rdata_zero", d_rdata, 0);
  endtask

  initial begin
    int k, n, both, early, rv;
    logic ord [0:3];
    reset_n  = 1'b1;
    if_req   = 1'b0;
    if_addr  = '0;
    d_req    = 1'b0;
    d_we     = 1'b0;
    d_addr   = '0;
    d_wdata  = '0;
    d_funct3 = '0;
    #3;
    reset_n = 1'b0;
    step();
    check("rst_busy", busy, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wren", mem_wren, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_rvalid", {if_rvalid, d_rvalid}, 0);
    step();
    reset_n = 1'b1;
    step();

    run_if(32'h1000, 32'h00500093);
    run_ld(32'h2008, 32'h5A5A2008);
    run_st(32'h2004, 32'hDEADBEEF);
    step();
    #1;
    check("hold_mem_addr", mem_addr, 32'h2004);
    check("hold_if_rdata", if_rdata, 32'h00500093);

    do_reset();
    if_req   = 1'b1;
    d_req    = 1'b1;
    d_we     = 1'b0;
    if_addr  = 32'h1100;
    d_addr   = 32'h2200;
    d_funct3 = 3'b010;
    #1;
    k = 0;
    n = 0;
    both = 0;
    while (k < 4 && n < 100) begin
      if (if_gnt && d_gnt) both++;
      if (if_gnt) begin ord[k] = 1'b0; k++; end
      else if (d_gnt) begin ord[k] = 1'b1; k++; end
      step();
      #1;
      n++;
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    check("rr_grants", k, 4);
    check("rr_order", {ord[0], ord[1], ord[2], ord[3]}, 4'b0101);
    check("rr_both_gnt", both, 0);
    n = 0;
    while (!d_rvalid && n < 20) begin
      step();
      #1;
      n++;
    end
    check("rr_d_rdata", d_rdata, 32'h5A5A2200);
    check("rr_if_rdata", if_rdata, 32'h5A5A1100);
`ifdef MEM_ARBITER_STATS_EN
    check("st_conflict_cnt", conflict_cnt, 16'd4);
    check("st_if_gnt_cnt", if_gnt_cnt, 16'd2);
    check("st_d_gnt_cnt", d_gnt_cnt, 16'd2);
`endif

    step();
    if_req  = 1'b1;
    if_addr = 32'h1000;
    #1;
    check("bz_if_gnt", if_gnt, 1);
    step();
    if_req   = 1'b0;
    d_req    = 1'b1;
    d_we     = 1'b0;
    d_addr   = 32'h2300;
    d_funct3 = 3'b000;
    #1;
    n = 1;
    early = 0;
    while (!if_rvalid && n < 20) begin
      if (d_gnt) early++;
      step();
      #1;
      n++;
    end
    if (d_gnt) early++;
    check("bz_no_early_gnt", early, 0);
    check("bz_if_latency", n, LAT + 2);
    step();
    #1;
    check("bz_d_gnt_idle", d_gnt, 1);
    step();
    d_req = 1'b0;
    #1;
    n = 1;
    while (!d_rvalid && n < 20) begin
      step();
      #1;
      n++;
    end
    check("bz_d_latency", n, LAT + 2);
    check("bz_d_rdata", d_rdata, 32'h5A5A2300);

    step();
    if_req  = 1'b1;
    if_addr = 32'h3000;
    #1;
    step();
    if_req = 1'b0;
    step();
    check("mid_busy_wait", busy, 1);
    reset_n = 1'b0;
    #1;
    check("mid_busy", busy, 0);
    check("mid_mem_addr", mem_addr, 0);
    check("mid_mem_f3", mem_funct3, 0);
    check("mid_if_rdata", if_rdata, 0);
    check("mid_rvalid", {if_rvalid, d_rvalid}, 0);
    step();
    step();
    reset_n = 1'b1;
    rv = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (if_rvalid || d_rvalid || busy) rv++;
    end
    check("mid_no_rvalid", rv, 0);
    run_if(32'h1000, 32'h00500093);

`ifdef MEM_ARBITER_STATS_EN
    step();
    force u_dut.if_cnt_q = 16'hFFFE;
    step();
    release u_dut.if_cnt_q;
    run_if(32'h1000, 32'h00500093);
    run_if(32'h1004, 32'h5A5A1004);
    run_if(32'h1008, 32'h5A5A1008);
    check("sat_if_gnt_cnt", if_gnt_cnt, 16'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
